clos_bcm: RTL and testbench
===========================

Name: clos_bcm

Overview:
- Clocked, buffered central module (CM) for the next-generation SDM-Clos router.
- Connects KN input ports to KN output ports with wormhole-style circuit allocation.
- Each output has its own arbiter (round-robin or fixed priority) and a BD-deep output FIFO.
- A circuit is held from grant until the eof flit passes, and each output exports a busy status (cms) back to the IMs.

Parameters:
KN, 5, number of input ports = number of output ports
DW, 32, flit data width per port
BD, 2, output FIFO depth in flits (power of 2, >=2)
RR, 1, 1 = round-robin arbitration, 0 = fixed priority (lowest index wins)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
di  in  KN x DW  input flit data
di4  in  KN  input eof (last flit of packet)
div  in  KN  input flit valid
dir  out  KN  input ready (flit consumed when div & dir)
ddec  in  KN x KN  per-input one-hot destination; stable while div is high
do  out  KN x DW  output flit data (FIFO head)
do4  out  KN  output eof (FIFO head)
dov  out  KN  output valid (= FIFO non-empty)
dor  in  KN  output ready from downstream
cms  out  KN  output j circuit busy (allocated to some input)

Behaviour:
- Reset (async, rst_n=0): dir=0, dov=0, do=0, do4=0, cms=0; all outputs IDLE; RR pointers=0; FIFOs empty.
- Request: input i requests output j when div[i] & ddec[i][j] & input i not currently owner of any output. Only the lowest set bit of ddec[i] counts (a non-one-hot ddec is a protocol error; the bench flags it).
- Per-output FSM, IDLE:
  - If any request is present, choose a winner (RR: first requester at or after ptr[j], cyclic; fixed: lowest index).
  - Register owner[j]=winner and move to BUSY on the next edge; cms[j]=1 from that edge.
  - An input can win at most one output per cycle. Conflicts are impossible because ddec is one-hot.
- Per-output FSM, BUSY:
  - dir[owner] = ~full[j] (combinational); all non-owner inputs see dir=0.
  - Push when div[owner] & dir[owner].
  - If the pushed flit has di4=1: go to IDLE on the same edge, cms[j]=0; in RR mode set ptr[j]=(owner+1) mod KN.
  - div low mid-packet: stay BUSY and hold the circuit indefinitely.
- Release and re-grant: a release on edge t makes the output IDLE for cycle t; the new winner is registered on edge t+1. Minimum gap between packets on one output is 1 idle cycle.
- Latency:
  - Request visible in cycle 0 → grant at edge 1 → dir=1 in cycle 1 if not full.
  - First flit enters FIFO at edge 2 → dov=1 in cycle 2.
  - Steady state is 1 flit/cycle per output when dor=1.
- FIFO:
  - BD entries of {DW data, eof}, with separate read/write pointers of width log2(BD)+1 and wrap-around.
  - Pop when dov & dor. Push and pop in the same cycle are legal when not full; count is unchanged.
  - When full, push is blocked via dir even if a pop occurs that cycle, so the full flag is registered-only.
- Single-flit packet (di4=1 on first flit): occupies BUSY for exactly one cycle.
- Reset mid-packet: circuit and FIFO contents are discarded immediately; upstream must restart the packet.
- A FIFO draining after release does not block a new grant.

Decomposition:
- Package clos_bcm_pkg: localparam IW=$clog2(KN), PW=$clog2(BD)+1; typedef flit_t = struct {logic [DW-1:0] data; logic eof;}; typedef state_e = {IDLE, BUSY}.
- Sub-module clos_bcm_fifo (one per output, parameters DW, BD): push/pop/full/empty. Arbiter logic stays inline with the per-output FSM in a generate loop.

Test Plan:
- Single packet: input 2 sends 3 flits (0xA1,0xA2,0xA3 eof) to output 4 with dor=1 → dov[4] rises in cycle 2, flits out in order on consecutive cycles, cms[4] high for 3 cycles, then 0.
- RR contention: inputs 0,1,3 all request output 1 in the same cycle, 1-flit packets, RR=1 → service order 0,1,3 with 1 idle cycle between grants; repeat with ptr=2 → order 3,0,1. With RR=0 → order 0,1,3 each time input 0 re-requests first.
- Backpressure: dor[0]=0 while input 1 sends 4 flits, BD=2 → exactly 2 flits accepted, dir[1]=0 afterwards; raising dor drains without loss or duplication.
- Parallel circuits: inputs 0→3 and 3→0 concurrently, 5 flits each → both at full rate, no cross-leakage of data.
- Stall and hold: div[owner] low for 10 cycles mid-packet → cms stays 1 and a competing requester for that output is not granted until eof.
- Async reset mid-packet: assert rst_n=0 between clock edges with FIFO holding 2 flits → dov, cms, dir are 0 immediately; after release, a fresh packet routes normally.

Source files
------------

// File: rtl/clos_bcm_pkg.sv
// Shared types and default sizing for the clos_bcm central module.
// Imported by the top level and by the bench.
package clos_bcm_pkg;

    localparam int KN_DEF = 5;
    localparam int DW_DEF = 32;
    localparam int BD_DEF = 2;

    localparam int IW = $clog2(KN_DEF);
    localparam int PW = $clog2(BD_DEF) + 1;

    typedef struct packed {
        logic [DW_DEF-1:0] data;
        logic              eof;
    } flit_t;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

endpackage

// File: rtl/clos_bcm_fifo.sv
// Per-output flit FIFO with wrap-bit pointers.
// Full is derived only from registered pointers.
module clos_bcm_fifo #(
    parameter int DW = 32,
    parameter int BD = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        push,
    input  logic        pop,
    input  logic [DW:0] wdata,
    output logic [DW:0] rdata,
    output logic        full,
    output logic        empty
);

    localparam int AW  = $clog2(BD);
    localparam int PTW = AW + 1;

    logic [DW:0]    mem [BD];
    logic [PTW-1:0] wp;
    logic [PTW-1:0] rp;

    assign empty = (wp == rp);
    assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
    assign rdata = empty ? '0 : mem[rp[AW-1:0]];

    // Advance read/write pointers on accepted push and pop.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wp <= '0;
            rp <= '0;
        end else begin
            if (push && !full)
                wp <= wp + PTW'(1);
            if (pop && !empty)
                rp <= rp + PTW'(1);
        end
    end

    // Storage array; contents are don't-care while empty.
    always_ff @(posedge clk) begin
        if (push && !full)
            mem[wp[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/clos_bcm.sv
// Buffered Clos central module: per-output arbiter,
// circuit FSM held until eof, and output FIFO.
module clos_bcm
    import clos_bcm_pkg::*;
#(
    parameter int KN = KN_DEF,
    parameter int DW = DW_DEF,
    parameter int BD = BD_DEF,
    parameter int RR = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic [KN-1:0][DW-1:0]  di,
    input  logic [KN-1:0]          di4,
    input  logic [KN-1:0]          div,
    output logic [KN-1:0]          dir,
    input  logic [KN-1:0][KN-1:0]  ddec,
    output logic [KN-1:0][DW-1:0]  do_data,
    output logic [KN-1:0]          do4,
    output logic [KN-1:0]          dov,
    input  logic [KN-1:0]          dor,
    output logic [KN-1:0]          cms
);

    localparam int SW = (KN > 1) ? $clog2(KN) : 1;

    logic [KN-1:0][KN-1:0] low;
    logic [KN-1:0]         owns;
    logic [KN-1:0]         own_mat [KN];
    logic [KN-1:0]         rdy_mat [KN];

    // Keep only the lowest destination bit of each input.
    always_comb begin
        low = '0;
        for (int i = 0; i < KN; i++)
            low[i] = ddec[i] & (~ddec[i] + KN'(1));
    end

    // Collect circuit ownership and per-input ready.
    always_comb begin
        dir  = '0;
        owns = '0;
        for (int j = 0; j < KN; j++) begin
            dir  = dir | rdy_mat[j];
            owns = owns | own_mat[j];
        end
    end

    for (genvar j = 0; j < KN; j++) begin : g_out
        state_e        state_q;
        state_e        state_d;
        logic [SW-1:0] owner_q;
        logic [SW-1:0] owner_d;
        logic [SW-1:0] ptr_q;
        logic [SW-1:0] ptr_d;
        logic [KN-1:0] req;
        logic [SW-1:0] win;
        logic          found;
        logic          busy;
        logic          full;
        logic          empty;
        logic          push;
        logic          pop;
        logic [DW:0]   head;

        assign busy       = (state_q == BUSY);
        assign own_mat[j] = busy ? (KN'(1) << owner_q) : '0;
        assign rdy_mat[j] = full ? '0 : own_mat[j];
        assign push       = busy && div[owner_q] && !full;
        assign pop        = !empty && dor[j];
        assign cms[j]     = busy;
        assign dov[j]     = !empty;
        assign do_data[j] = head[DW:1];
        assign do4[j]     = head[0];

        // Requests from free inputs aimed at this output.
        always_comb begin
            req = '0;
            for (int i = 0; i < KN; i++)
                req[i] = div[i] && !owns[i] && low[i][j];
        end

        // Pick the first requester from ptr (RR) or from 0.
        always_comb begin
            int c;
            c     = 0;
            win   = '0;
            found = 1'b0;
            for (int k = 0; k < KN; k++) begin
                c = (RR != 0) ? ((int'(ptr_q) + k) % KN) : k;
                if (!found && req[c]) begin
                    found = 1'b1;
                    win   = SW'(c);
                end
            end
        end

        // Circuit FSM: grant from IDLE, release on pushed eof.
        always_comb begin
            state_d = state_q;
            owner_d = owner_q;
            ptr_d   = ptr_q;
            unique case (state_q)
                IDLE: begin
                    if (found) begin
                        state_d = BUSY;
                        owner_d = win;
                    end
                end
                BUSY: begin
                    if (push && di4[owner_q]) begin
                        state_d = IDLE;
                        if (RR != 0)
                            ptr_d = (owner_q == SW'(KN - 1))
                                  ? '0 : owner_q + SW'(1);
                    end
                end
            endcase
        end

        // Circuit state, owner and round-robin pointer.
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                state_q <= IDLE;
                owner_q <= '0;
                ptr_q   <= '0;
            end else begin
                state_q <= state_d;
                owner_q <= owner_d;
                ptr_q   <= ptr_d;
            end
        end

        clos_bcm_fifo #(
            .DW (DW),
            .BD (BD)
        ) u_fifo (
            .clk   (clk),
            .rst_n (rst_n),
            .push  (push),
            .pop   (pop),
            .wdata ({di[owner_q], di4[owner_q]}),
            .rdata (head),
            .full  (full),
            .empty (empty)
        );
    end

endmodule

// File: tb/tb_clos_bcm.sv
// Directed bench for clos_bcm: one RR and one fixed-priority
// instance share stimulus; sel picks which one drives handshakes.
module tb_clos_bcm;
    import clos_bcm_pkg::*;

    localparam int N = 5;
    localparam int W = 32;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [N-1:0][W-1:0] di;
    logic [N-1:0] di4, div, dor;
    logic [N-1:0][N-1:0] ddec;

    logic [N-1:0] dir_a, dov_a, do4_a, cms_a;
    logic [N-1:0][W-1:0] dd_a;
    logic [N-1:0] dir_b, dov_b, do4_b, cms_b;
    logic [N-1:0][W-1:0] dd_b;

    logic sel = 1'b0;
    logic [N-1:0] dir_s, dov_s, do4_s, cms_s;
    logic [N-1:0][W-1:0] dd_s;

    assign dir_s = sel ? dir_b : dir_a;
    assign dov_s = sel ? dov_b : dov_a;
    assign do4_s = sel ? do4_b : do4_a;
    assign cms_s = sel ? cms_b : cms_a;
    assign dd_s  = sel ? dd_b  : dd_a;

    flit_t src [N][16];
    int hd [N];
    int tl [N];
    int dst [N];
    logic [N-1:0] stall;
    flit_t olog [N][32];
    int ocyc [N][32];
    int ocnt [N];
    logic [N-1:0] acc;

    int cyc = 0;
    int checks = 0;
    int errors = 0;

    clos_bcm #(.KN(N), .DW(W), .BD(2), .RR(1)) dut_a (
        .clk(clk), .rst_n(rst_n), .di(di), .di4(di4), .div(div),
        .dir(dir_a), .ddec(ddec), .do_data(dd_a), .do4(do4_a),
        .dov(dov_a), .dor(dor), .cms(cms_a)
    );

    clos_bcm #(.KN(N), .DW(W), .BD(2), .RR(0)) dut_b (
        .clk(clk), .rst_n(rst_n), .di(di), .di4(di4), .div(div),
        .dir(dir_b), .ddec(ddec), .do_data(dd_b), .do4(do4_b),
        .dov(dov_b), .dor(dor), .cms(cms_b)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic refresh();
        for (int i = 0; i < N; i++) begin
            div[i]  = (hd[i] < tl[i]) && !stall[i];
            di[i]   = (hd[i] < tl[i]) ? src[i][hd[i]].data : '0;
            di4[i]  = (hd[i] < tl[i]) ? src[i][hd[i]].eof : 1'b0;
            ddec[i] = N'(1) << dst[i];
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #3;
    endtask

    task automatic push_flit(input int i, input logic [W-1:0] d,
                             input logic e);
        if (tl[i] < 16) begin
            src[i][tl[i]] = '{data: d, eof: e};
            tl[i]++;
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) begin
            hd[i] = 0;
            tl[i] = 0;
            dst[i] = 0;
            ocnt[i] = 0;
        end
        stall = '0;
        dor = '1;
        refresh();
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    // Handshake driver and output monitor.
    initial begin
        forever begin
            @(negedge clk);
            acc = div & dir_s;
            for (int j = 0; j < N; j++) begin
                if (dov_s[j] && dor[j] && ocnt[j] < 32) begin
                    olog[j][ocnt[j]] = '{data: dd_s[j], eof: do4_s[j]};
                    ocyc[j][ocnt[j]] = cyc;
                    ocnt[j]++;
                end
            end
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++)
                if (acc[i]) hd[i]++;
            refresh();
        end
    end

    task automatic test_reset();
        rst_n = 1'b0;
        for (int i = 0; i < N; i++) begin
            hd[i] = 0; tl[i] = 0; dst[i] = 1; ocnt[i] = 0;
        end
        stall = '0;
        dor = '1;
        push_flit(0, 32'h5, 1'b1);
        refresh();
        tick();
        tick();
        checks++;
        if (dir_a !== '0 || dir_b !== '0) begin
            errors++;
            $display("FAIL reset_dir: got %b/%b expected 0", dir_a, dir_b);
        end
        checks++;
        if (dov_a !== '0 || dov_b !== '0) begin
            errors++;
            $display("FAIL reset_dov: got %b/%b expected 0", dov_a, dov_b);
        end
        checks++;
        if (cms_a !== '0 || cms_b !== '0) begin
            errors++;
            $display("FAIL reset_cms: got %b/%b expected 0", cms_a, cms_b);
        end
        checks++;
        if (dd_a !== '0 || do4_a !== '0) begin
            errors++;
            $display("FAIL reset_do: got %h/%b expected 0", dd_a, do4_a);
        end
    endtask

    task automatic test_single();
        logic ex_c, ex_v, ex_r;
        logic [W-1:0] ed;
        do_reset();
        sel = 1'b0;
        dst[2] = 4;
        push_flit(2, 32'hA1, 1'b0);
        push_flit(2, 32'hA2, 1'b0);
        push_flit(2, 32'hA3, 1'b1);
        refresh();
        for (int k = 0; k < 7; k++) begin
            if (k > 0) tick();
            ex_c = (k >= 1 && k <= 3);
            ex_r = (k >= 1 && k <= 3);
            ex_v = (k >= 2 && k <= 4);
            checks++;
            if (cms_s[4] !== ex_c) begin
                errors++;
                $display("FAIL single_cms[%0d]: got %b expected %b",
                         k, cms_s[4], ex_c);
            end
            checks++;
            if (dov_s[4] !== ex_v) begin
                errors++;
                $display("FAIL single_dov[%0d]: got %b expected %b",
                         k, dov_s[4], ex_v);
            end
            checks++;
            if (dir_s[2] !== ex_r) begin
                errors++;
                $display("FAIL single_dir[%0d]: got %b expected %b",
                         k, dir_s[2], ex_r);
            end
            if (ex_v) begin
                ed = 32'hA0 + k - 1;
                checks++;
                if (dd_s[4] !== ed || do4_s[4] !== (k == 4)) begin
                    errors++;
                    $display("FAIL single_data[%0d]: got %h/%b expected %h/%b",
                             k, dd_s[4], do4_s[4], ed, (k == 4));
                end
            end
        end
    endtask

    task automatic test_rr();
        int c0;
        logic [W-1:0] e1 [3];
        logic [W-1:0] e2 [4];
        e1 = '{32'h10, 32'h11, 32'h13};
        e2 = '{32'h21, 32'h33, 32'h30, 32'h31};
        do_reset();
        sel = 1'b0;
        dst[0] = 1; dst[1] = 1; dst[3] = 1;
        push_flit(0, 32'h10, 1'b1);
        push_flit(1, 32'h11, 1'b1);
        push_flit(3, 32'h13, 1'b1);
        refresh();
        c0 = cyc;
        repeat (9) tick();
        checks++;
        if (ocnt[1] !== 3) begin
            errors++;
            $display("FAIL rr_count: got %0d expected 3", ocnt[1]);
        end
        for (int n = 0; n < 3; n++) begin
            checks++;
            if (olog[1][n].data !== e1[n] || ocyc[1][n] !== c0 + 2 + 2 * n) begin
                errors++;
                $display("FAIL rr_order[%0d]: got %h@%0d expected %h@%0d",
                         n, olog[1][n].data, ocyc[1][n] - c0, e1[n], 2 + 2 * n);
            end
        end
        ocnt[1] = 0;
        push_flit(1, 32'h21, 1'b1);
        refresh();
        repeat (5) tick();
        push_flit(0, 32'h30, 1'b1);
        push_flit(1, 32'h31, 1'b1);
        push_flit(3, 32'h33, 1'b1);
        refresh();
        c0 = cyc;
        repeat (9) tick();
        checks++;
        if (ocnt[1] !== 4) begin
            errors++;
            $display("FAIL rr_ptr_count: got %0d expected 4", ocnt[1]);
        end
        for (int n = 0; n < 4; n++) begin
            checks++;
            if (olog[1][n].data !== e2[n]) begin
                errors++;
                $display("FAIL rr_ptr_order[%0d]: got %h expected %h",
                         n, olog[1][n].data, e2[n]);
            end
        end
        checks++;
        if (ocyc[1][3] !== c0 + 6) begin
            errors++;
            $display("FAIL rr_ptr_gap: got %0d expected 6", ocyc[1][3] - c0);
        end
    endtask

    task automatic test_fixed();
        int c0;
        logic [W-1:0] e [4];
        e = '{32'h40, 32'h41, 32'h42, 32'h43};
        do_reset();
        sel = 1'b1;
        dst[0] = 1; dst[1] = 1; dst[3] = 1;
        push_flit(0, 32'h40, 1'b1);
        push_flit(0, 32'h41, 1'b1);
        push_flit(1, 32'h42, 1'b1);
        push_flit(3, 32'h43, 1'b1);
        refresh();
        c0 = cyc;
        repeat (12) tick();
        checks++;
        if (ocnt[1] !== 4) begin
            errors++;
            $display("FAIL fixed_count: got %0d expected 4", ocnt[1]);
        end
        for (int n = 0; n < 4; n++) begin
            checks++;
            if (olog[1][n].data !== e[n] || ocyc[1][n] !== c0 + 2 + 2 * n) begin
                errors++;
                $display("FAIL fixed_order[%0d]: got %h@%0d expected %h@%0d",
                         n, olog[1][n].data, ocyc[1][n] - c0, e[n], 2 + 2 * n);
            end
        end
        sel = 1'b0;
    endtask

    task automatic test_backpressure();
        do_reset();
        sel = 1'b0;
        dor[0] = 1'b0;
        dst[1] = 0;
        for (int n = 0; n < 4; n++)
            push_flit(1, 32'h50 + n, n == 3);
        refresh();
        repeat (8) tick();
        checks++;
        if (hd[1] !== 2) begin
            errors++;
            $display("FAIL bp_accepted: got %0d expected 2", hd[1]);
        end
        checks++;
        if (dir_s[1] !== 1'b0) begin
            errors++;
            $display("FAIL bp_dir: got %b expected 0", dir_s[1]);
        end
        checks++;
        if (dov_s[0] !== 1'b1 || dd_s[0] !== 32'h50) begin
            errors++;
            $display("FAIL bp_head: got %b/%h expected 1/50", dov_s[0], dd_s[0]);
        end
        checks++;
        if (cms_s[0] !== 1'b1) begin
            errors++;
            $display("FAIL bp_cms: got %b expected 1", cms_s[0]);
        end
        dor[0] = 1'b1;
        repeat (8) tick();
        checks++;
        if (ocnt[0] !== 4) begin
            errors++;
            $display("FAIL bp_drain_count: got %0d expected 4", ocnt[0]);
        end
        for (int n = 0; n < 4; n++) begin
            checks++;
            if (olog[0][n].data !== 32'h50 + n || olog[0][n].eof !== (n == 3)) begin
                errors++;
                $display("FAIL bp_drain[%0d]: got %h/%b expected %h/%b",
                         n, olog[0][n].data, olog[0][n].eof, 32'h50 + n, (n == 3));
            end
        end
        checks++;
        if (cms_s[0] !== 1'b0) begin
            errors++;
            $display("FAIL bp_release: got %b expected 0", cms_s[0]);
        end
    endtask

    task automatic test_parallel();
        int c0;
        do_reset();
        sel = 1'b0;
        dst[0] = 3;
        dst[3] = 0;
        for (int n = 0; n < 5; n++) begin
            push_flit(0, 32'h60 + n, n == 4);
            push_flit(3, 32'h70 + n, n == 4);
        end
        refresh();
        c0 = cyc;
        repeat (9) tick();
        checks++;
        if (ocnt[3] !== 5 || ocnt[0] !== 5) begin
            errors++;
            $display("FAIL par_count: got %0d/%0d expected 5/5", ocnt[3], ocnt[0]);
        end
        for (int n = 0; n < 5; n++) begin
            checks++;
            if (olog[3][n].data !== 32'h60 + n || ocyc[3][n] !== c0 + 2 + n) begin
                errors++;
                $display("FAIL par_o3[%0d]: got %h@%0d expected %h@%0d",
                         n, olog[3][n].data, ocyc[3][n] - c0, 32'h60 + n, 2 + n);
            end
            checks++;
            if (olog[0][n].data !== 32'h70 + n || ocyc[0][n] !== c0 + 2 + n) begin
                errors++;
                $display("FAIL par_o0[%0d]: got %h@%0d expected %h@%0d",
                         n, olog[0][n].data, ocyc[0][n] - c0, 32'h70 + n, 2 + n);
            end
        end
        checks++;
        if (ocnt[1] + ocnt[2] + ocnt[4] !== 0) begin
            errors++;
            $display("FAIL par_leak: got %0d expected 0",
                     ocnt[1] + ocnt[2] + ocnt[4]);
        end
    endtask

    task automatic test_stall();
        logic [W-1:0] e [4];
        e = '{32'h80, 32'h81, 32'h82, 32'h90};
        do_reset();
        sel = 1'b0;
        dst[2] = 4;
        push_flit(2, 32'h80, 1'b0);
        push_flit(2, 32'h81, 1'b0);
        push_flit(2, 32'h82, 1'b1);
        refresh();
        tick();
        tick();
        stall[2] = 1'b1;
        dst[0] = 4;
        push_flit(0, 32'h90, 1'b1);
        refresh();
        for (int k = 0; k < 10; k++) begin
            checks++;
            if (cms_s[4] !== 1'b1 || dir_s[0] !== 1'b0) begin
                errors++;
                $display("FAIL stall_hold[%0d]: got cms %b dir0 %b expected 1 0",
                         k, cms_s[4], dir_s[0]);
            end
            tick();
        end
        checks++;
        if (ocnt[4] !== 1) begin
            errors++;
            $display("FAIL stall_out: got %0d expected 1", ocnt[4]);
        end
        stall[2] = 1'b0;
        refresh();
        repeat (8) tick();
        checks++;
        if (ocnt[4] !== 4) begin
            errors++;
            $display("FAIL stall_count: got %0d expected 4", ocnt[4]);
        end
        for (int n = 0; n < 4; n++) begin
            checks++;
            if (olog[4][n].data !== e[n]) begin
                errors++;
                $display("FAIL stall_order[%0d]: got %h expected %h",
                         n, olog[4][n].data, e[n]);
            end
        end
    endtask

    task automatic test_async_reset();
        int c0;
        do_reset();
        sel = 1'b0;
        dor[2] = 1'b0;
        dst[4] = 2;
        for (int n = 0; n < 4; n++)
            push_flit(4, 32'hB0 + n, n == 3);
        refresh();
        repeat (6) tick();
        checks++;
        if (dov_s[2] !== 1'b1 || cms_s[2] !== 1'b1 || hd[4] !== 2) begin
            errors++;
            $display("FAIL arst_pre: got dov %b cms %b acc %0d expected 1 1 2",
                     dov_s[2], cms_s[2], hd[4]);
        end
        rst_n = 1'b0;
        #1;
        checks++;
        if (dov_s !== '0 || cms_s !== '0 || dir_s !== '0) begin
            errors++;
            $display("FAIL arst_now: got dov %b cms %b dir %b expected 0",
                     dov_s, cms_s, dir_s);
        end
        do_reset();
        dst[4] = 2;
        push_flit(4, 32'hC0, 1'b0);
        push_flit(4, 32'hC1, 1'b1);
        refresh();
        c0 = cyc;
        repeat (6) tick();
        checks++;
        if (ocnt[2] !== 2) begin
            errors++;
            $display("FAIL arst_count: got %0d expected 2", ocnt[2]);
        end
        for (int n = 0; n < 2; n++) begin
            checks++;
            if (olog[2][n].data !== 32'hC0 + n || olog[2][n].eof !== (n == 1)
                || ocyc[2][n] !== c0 + 2 + n) begin
                errors++;
                $display("FAIL arst_after[%0d]: got %h/%b@%0d expected %h/%b@%0d",
                         n, olog[2][n].data, olog[2][n].eof, ocyc[2][n] - c0,
                         32'hC0 + n, (n == 1), 2 + n);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_rr();
        test_fixed();
        test_backpressure();
        test_parallel();
        test_stall();
        test_async_reset();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
